ssp_peer: RTL and testbench

SSP_PEER -- requirements
Module: ssp_peer

---
 rtl/ssp_pkg.sv | 11 +
 rtl/ssp_peer_if.sv | 16 +
 rtl/ssp_peer_fifo.sv | 43 ++++
 rtl/ssp_peer.sv | 189 ++++++++++++++++++
 tb/tb_ssp_peer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssp_pkg.sv
// rtl/ssp_pkg.sv - shared widths, FIFO geometry and FSM state encodings for ssp_peer
package ssp_pkg;
  localparam int WORD_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int BIT_CNT_W  = $clog2(WORD_W);

  typedef enum logic {R_IDLE, R_SHIFT} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_SYNC, T_SHIFT} tx_state_e;
endpackage

// File: rtl/ssp_peer_if.sv
// rtl/ssp_peer_if.sv - local byte-side transmit/receive handshake for ssp_peer
interface ssp_peer_if;
  import ssp_pkg::*;
  logic              TX_VALID;
  logic [WORD_W-1:0] TX_DATA;
  logic              TX_READY;
  logic              RX_VALID;
  logic [WORD_W-1:0] RX_DATA;
  logic              RX_READY;
  logic              RX_OVERRUN;

  modport master (output TX_VALID, TX_DATA, RX_READY,
                  input  TX_READY, RX_VALID, RX_DATA, RX_OVERRUN);
  modport slave  (input  TX_VALID, TX_DATA, RX_READY,
                  output TX_READY, RX_VALID, RX_DATA, RX_OVERRUN);
endinterface

// File: rtl/ssp_peer_fifo.sv
// rtl/ssp_peer_fifo.sv - 4x8 synchronous first-word-fall-through FIFO with full/empty
module ssp_peer_fifo
  import ssp_pkg::*;
(
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A write into a full FIFO lands only when the head leaves in the same cycle.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
endmodule

// File: rtl/ssp_peer.sv
// rtl/ssp_peer.sv - SSP link peer: serial RX/TX with byte FIFOs; SSP_PEER_LOOPBACK_EN adds LOOPBACK input
module ssp_peer
  import ssp_pkg::*;
(
  input  logic PCLK,
  input  logic CLEAR_B,
  input  logic LNKCLK,
  input  logic LNKFSS,
  input  logic LNKRXD,
  input  logic LNKOE_B,
`ifdef SSP_PEER_LOOPBACK_EN
  input  logic LOOPBACK,
`endif
  ssp_peer_if.slave bus,
  output logic PEERCLKOUT,
  output logic PEERFSSOUT,
  output logic PEERTXD,
  output logic PEEROE_B
);
  logic w_rx_clk, w_rx_fss, w_rx_dat, w_rx_oe_b;
  logic r_clk_out, r_fss, r_txd, r_oe_b;

`ifdef SSP_PEER_LOOPBACK_EN
  assign w_rx_clk  = LOOPBACK ? r_clk_out : LNKCLK;
  assign w_rx_fss  = LOOPBACK ? r_fss     : LNKFSS;
  assign w_rx_dat  = LOOPBACK ? r_txd     : LNKRXD;
  assign w_rx_oe_b = LOOPBACK ? r_oe_b    : LNKOE_B;
`else
  assign w_rx_clk  = LNKCLK;
  assign w_rx_fss  = LNKFSS;
  assign w_rx_dat  = LNKRXD;
  assign w_rx_oe_b = LNKOE_B;
`endif

  // Receiver
  rx_state_e            r_rx_state, w_rx_state_nx;
  logic [BIT_CNT_W-1:0] r_rx_cnt, w_rx_cnt_nx;
  logic [WORD_W-1:0]    r_rx_sh, w_rx_sh_nx;
  logic                 r_rx_wr, w_rx_wr_nx;
  logic                 r_lnk_clk_d, r_overrun;
  logic                 w_rx_rise, w_rx_full, w_rx_empty, w_rx_pop, w_rx_push;

  assign w_rx_rise = w_rx_clk & ~r_lnk_clk_d;
  assign w_rx_pop  = bus.RX_READY & ~w_rx_empty;
  assign w_rx_push = r_rx_wr & (~w_rx_full | w_rx_pop);

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt;
    w_rx_sh_nx    = r_rx_sh;
    w_rx_wr_nx    = 1'b0;
    case (r_rx_state)
      R_IDLE: begin
        if (w_rx_rise && w_rx_fss && !w_rx_oe_b) begin
          w_rx_state_nx = R_SHIFT;
          w_rx_cnt_nx   = '0;
        end
      end
      R_SHIFT: begin
        if (w_rx_rise) begin
          w_rx_sh_nx  = {r_rx_sh[WORD_W-2:0], w_rx_dat};
          w_rx_cnt_nx = r_rx_cnt + 1'b1;
          if (r_rx_cnt == BIT_CNT_W'(WORD_W - 1)) begin
            w_rx_state_nx = R_IDLE;
            w_rx_wr_nx    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      r_rx_state  <= R_IDLE;
      r_rx_cnt    <= '0;
      r_rx_sh     <= '0;
      r_rx_wr     <= 1'b0;
      r_lnk_clk_d <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_state_nx;
      r_rx_cnt    <= w_rx_cnt_nx;
      r_rx_sh     <= w_rx_sh_nx;
      r_rx_wr     <= w_rx_wr_nx;
      r_lnk_clk_d <= w_rx_clk;
      if (r_rx_wr && !w_rx_push) r_overrun <= 1'b1;
    end
  end

  ssp_peer_fifo u_rx_fifo (
    .PCLK    (PCLK),
    .CLEAR_B (CLEAR_B),
    .i_push  (w_rx_push),
    .i_wdata (r_rx_sh),
    .i_pop   (w_rx_pop),
    .o_rdata (bus.RX_DATA),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign bus.RX_VALID   = ~w_rx_empty;
  assign bus.RX_OVERRUN = r_overrun;

  // Transmitter: all state moves on the cycle PEERCLKOUT falls, so data is
  // stable half a serial period before the peer's rising-edge sample.
  tx_state_e            r_tx_state, w_tx_state_nx;
  logic [BIT_CNT_W-1:0] r_tx_cnt, w_tx_cnt_nx;
  logic [WORD_W-1:0]    r_tx_sh, w_tx_sh_nx, w_tx_rdata;
  logic                 w_fss_nx, w_txd_nx, w_oe_b_nx;
  logic                 w_tick, w_tx_pop, w_tx_full, w_tx_empty, w_tx_ready;

  assign w_tick     = r_clk_out;
  assign w_tx_ready = ~w_tx_full;

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_sh_nx    = r_tx_sh;
    w_fss_nx      = r_fss;
    w_txd_nx      = r_txd;
    w_oe_b_nx     = r_oe_b;
    w_tx_pop      = 1'b0;
    if (w_tick) begin
      case (r_tx_state)
        T_IDLE, T_SHIFT: begin
          if (r_tx_state == T_SHIFT && r_tx_cnt != '0) begin
            w_txd_nx    = r_tx_sh[r_tx_cnt - 1'b1];
            w_tx_cnt_nx = r_tx_cnt - 1'b1;
          end else if (!w_tx_empty) begin
            w_tx_pop      = 1'b1;
            w_tx_sh_nx    = w_tx_rdata;
            w_fss_nx      = 1'b1;
            w_oe_b_nx     = 1'b0;
            w_txd_nx      = 1'b0;
            w_tx_state_nx = T_SYNC;
          end else begin
            w_oe_b_nx     = 1'b1;
            w_txd_nx      = 1'b0;
            w_tx_state_nx = T_IDLE;
          end
        end
        T_SYNC: begin
          w_fss_nx      = 1'b0;
          w_txd_nx      = r_tx_sh[WORD_W-1];
          w_tx_cnt_nx   = BIT_CNT_W'(WORD_W - 1);
          w_tx_state_nx = T_SHIFT;
        end
        default: w_tx_state_nx = T_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= '0;
      r_tx_sh    <= '0;
      r_clk_out  <= 1'b0;
      r_fss      <= 1'b0;
      r_txd      <= 1'b0;
      r_oe_b     <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_sh    <= w_tx_sh_nx;
      r_clk_out  <= ~r_clk_out;
      r_fss      <= w_fss_nx;
      r_txd      <= w_txd_nx;
      r_oe_b     <= w_oe_b_nx;
    end
  end

  ssp_peer_fifo u_tx_fifo (
    .PCLK    (PCLK),
    .CLEAR_B (CLEAR_B),
    .i_push  (bus.TX_VALID & w_tx_ready),
    .i_wdata (bus.TX_DATA),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_rdata),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  assign bus.TX_READY = w_tx_ready;
  assign PEERCLKOUT   = r_clk_out;
  assign PEERFSSOUT   = r_fss;
  assign PEERTXD      = r_txd;
  assign PEEROE_B     = r_oe_b;
endmodule

// File: tb/tb_ssp_peer.sv
// tb/tb_ssp_peer.sv - randomized self-checking bench for ssp_peer against a queue-based frame model
module tb_ssp_peer;
  import ssp_pkg::*;

  logic PCLK = 1'b0;
  logic CLEAR_B = 1'b0;
  logic drv_clk = 1'b0, drv_fss = 1'b0, drv_rxd = 1'b0, drv_oe_b = 1'b1;
  logic r_loop = 1'b0;
  logic lnk_clk, lnk_fss, lnk_rxd, lnk_oe_b;
  logic peer_clk, peer_fss, peer_txd, peer_oe_b;

  ssp_peer_if bus();

`ifdef SSP_PEER_LOOPBACK_EN
  assign lnk_clk  = drv_clk;
  assign lnk_fss  = drv_fss;
  assign lnk_rxd  = drv_rxd;
  assign lnk_oe_b = drv_oe_b;
`else
  assign lnk_clk  = r_loop ? peer_clk  : drv_clk;
  assign lnk_fss  = r_loop ? peer_fss  : drv_fss;
  assign lnk_rxd  = r_loop ? peer_txd  : drv_rxd;
  assign lnk_oe_b = r_loop ? peer_oe_b : drv_oe_b;
`endif

  ssp_peer dut (
    .PCLK       (PCLK),
    .CLEAR_B    (CLEAR_B),
    .LNKCLK     (lnk_clk),
    .LNKFSS     (lnk_fss),
    .LNKRXD     (lnk_rxd),
    .LNKOE_B    (lnk_oe_b),
`ifdef SSP_PEER_LOOPBACK_EN
    .LOOPBACK   (r_loop),
`endif
    .bus        (bus),
    .PEERCLKOUT (peer_clk),
    .PEERFSSOUT (peer_fss),
    .PEERTXD    (peer_txd),
    .PEEROE_B   (peer_oe_b)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int mon_period = 0;
  int mon_oe_low = 0;
  int mon_starts[$];
  int lb_got;
  int tx_acc;
  bit ok;
  logic [7:0] d;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decodes the serial transmit stream as a peer would and matches bytes in push order.
  initial begin : tx_monitor
    logic prev;
    logic active;
    int bits;
    logic [7:0] sh;
    prev = 1'b0; active = 1'b0; bits = 0; sh = '0;
    forever begin
      @(negedge PCLK);
      if (!CLEAR_B) begin
        prev = 1'b0;
        active = 1'b0;
      end else begin
        if (peer_clk && !prev) begin
          mon_period++;
          if (!peer_oe_b) mon_oe_low++;
          if (active) begin
            sh = {sh[6:0], peer_txd};
            bits++;
            if (bits == 8) begin
              active = 1'b0;
              if (tx_exp.size() == 0) check("tx_unexpected_byte", int'(sh), 256);
              else check("tx_byte", int'(sh), int'(tx_exp.pop_front()));
            end
          end else if (peer_fss && !peer_oe_b) begin
            active = 1'b1;
            bits = 0;
            mon_starts.push_back(mon_period);
          end
        end
        prev = peer_clk;
      end
    end
  end

  task automatic apply_reset();
    bus.TX_VALID = 1'b0;
    bus.RX_READY = 1'b0;
    CLEAR_B = 1'b0;
    repeat (2) begin @(posedge PCLK); #1; end
    tx_exp.delete();
    rx_exp.delete();
    CLEAR_B = 1'b1;
  endtask

  task automatic tx_push(input logic [7:0] b, input int budget, output bit taken);
    bus.TX_VALID = 1'b1;
    bus.TX_DATA = b;
    taken = 1'b0;
    for (int i = 0; i < budget && !taken; i++) begin
      @(negedge PCLK);
      if (bus.TX_READY) taken = 1'b1;
      @(posedge PCLK); #1;
    end
    bus.TX_VALID = 1'b0;
    if (taken) begin
      tx_exp.push_back(b);
      if (r_loop) rx_exp.push_back(b);
    end
  endtask

  task automatic rx_pop(output logic [7:0] data, output bit got);
    got = 1'b0;
    data = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge PCLK);
      if (bus.RX_VALID) begin
        got = 1'b1;
        data = bus.RX_DATA;
      end
    end
    if (got) begin
      bus.RX_READY = 1'b1;
      @(posedge PCLK); #1;
      bus.RX_READY = 1'b0;
    end
  endtask

  task automatic lnk_send(input logic [7:0] b);
    @(posedge PCLK); #1;
    drv_clk = 1'b0; drv_fss = 1'b1; drv_oe_b = 1'b0; drv_rxd = 1'b0;
    @(posedge PCLK); #1;
    drv_clk = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      @(posedge PCLK); #1;
      drv_clk = 1'b0; drv_fss = 1'b0; drv_rxd = b[i];
      @(posedge PCLK); #1;
      drv_clk = 1'b1;
    end
    @(posedge PCLK); #1;
    drv_clk = 1'b0; drv_oe_b = 1'b1; drv_rxd = 1'b0;
  endtask

  task automatic wait_tx_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge PCLK);
      if (tx_exp.size() == 0 && peer_oe_b) break;
    end
    check("tx_drain", tx_exp.size(), 0);
    @(posedge PCLK); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clk"}, peer_clk, 0);
    check({tag, "_fss"}, peer_fss, 0);
    check({tag, "_txd"}, peer_txd, 0);
    check({tag, "_oe_b"}, peer_oe_b, 1);
    check({tag, "_rx_valid"}, bus.RX_VALID, 0);
    check({tag, "_rx_data"}, bus.RX_DATA, 0);
    check({tag, "_overrun"}, bus.RX_OVERRUN, 0);
    check({tag, "_tx_ready"}, bus.TX_READY, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.TX_VALID = 1'b0;
    bus.TX_DATA = '0;
    bus.RX_READY = 1'b0;
    @(posedge PCLK); #1;
    check_reset_outputs("reset");
    apply_reset();

    repeat (20) begin @(posedge PCLK); #1; end
    check("idle_oe_b", peer_oe_b, 1);
    check("idle_fss", peer_fss, 0);
    check("idle_tx_ready", bus.TX_READY, 1);
    check("idle_rx_valid", bus.RX_VALID, 0);

    lnk_send(8'hA5);
    check("a5_not_yet", bus.RX_VALID, 0);
    @(posedge PCLK); #1;
    check("a5_valid", bus.RX_VALID, 1);
    check("a5_data", bus.RX_DATA, 8'hA5);
    bus.RX_READY = 1'b1;
    @(posedge PCLK); #1;
    bus.RX_READY = 1'b0;
    check("a5_popped", bus.RX_VALID, 0);

    mon_starts.delete();
    mon_oe_low = 0;
    tx_push(8'h3C, 5, ok);
    check("push_3c", ok, 1);
    tx_push(8'hC3, 5, ok);
    check("push_c3", ok, 1);
    wait_tx_done(200);
    check("b2b_frames", mon_starts.size(), 2);
    if (mon_starts.size() == 2) check("b2b_gap", mon_starts[1] - mon_starts[0], 9);
    check("b2b_oe_low", mon_oe_low, 18);

    apply_reset();
    tx_acc = 0;
    bus.TX_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.TX_DATA = 8'h10 + 8'(i);
      @(negedge PCLK);
      if (!bus.TX_READY) break;
      tx_exp.push_back(bus.TX_DATA);
      tx_acc++;
      @(posedge PCLK); #1;
    end
    check("fill_accepted", tx_acc, 5);
    bus.TX_DATA = 8'hE7;
    repeat (4) @(posedge PCLK);
    #1;
    check("fill_held", bus.TX_READY, 0);
    tx_push(8'hE7, 40, ok);
    check("fill_after_pop", ok, 1);
    wait_tx_done(400);

    apply_reset();
    for (int i = 1; i <= 4; i++) lnk_send(8'(i));
    @(posedge PCLK); #1;
    check("ovr_before", bus.RX_OVERRUN, 0);
    check("ovr_full", bus.TX_READY & bus.RX_VALID, 1);
    lnk_send(8'h05);
    @(posedge PCLK); #1;
    check("ovr_set", bus.RX_OVERRUN, 1);
    for (int i = 1; i <= 4; i++) begin
      rx_pop(d, ok);
      check("ovr_pop_ok", ok, 1);
      check("ovr_data", d, i);
    end
    check("ovr_drained", bus.RX_VALID, 0);
    check("ovr_sticky", bus.RX_OVERRUN, 1);

    apply_reset();
    r_loop = 1'b1;
    tx_push(8'h5A, 5, ok);
    rx_pop(d, ok);
    check("lb_5a_ok", ok, 1);
    check("lb_5a_data", d, 8'h5A);
    rx_exp.delete();

    lb_got = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 20)) begin @(posedge PCLK); #1; end
          tx_push(8'($urandom), 100, ok);
          check("lb_push_ok", ok, 1);
        end
      end
      begin
        for (int c = 0; c < 3000 && lb_got < 12; c++) begin
          @(negedge PCLK);
          if (bus.RX_VALID && ($urandom_range(0, 1) == 1)) begin
            if (rx_exp.size() == 0) check("lb_unexpected", bus.RX_DATA, 256);
            else check("lb_byte", bus.RX_DATA, rx_exp.pop_front());
            lb_got++;
            bus.RX_READY = 1'b1;
            @(posedge PCLK); #1;
            bus.RX_READY = 1'b0;
          end
        end
      end
    join
    check("lb_count", lb_got, 12);
    check("lb_no_overrun", bus.RX_OVERRUN, 0);
    wait_tx_done(200);

    tx_push(8'h5A, 5, ok);
    repeat (10) begin @(posedge PCLK); #1; end
    check("mid_active", peer_oe_b, 0);
    CLEAR_B = 1'b0;
    @(posedge PCLK); #1;
    check_reset_outputs("mid_reset");
    tx_exp.delete();
    rx_exp.delete();
    CLEAR_B = 1'b1;
    repeat (40) begin @(posedge PCLK); #1; end
    check("mid_no_rx", bus.RX_VALID, 0);
    check("mid_oe_b", peer_oe_b, 1);
    check("mid_overrun", bus.RX_OVERRUN, 0);
    r_loop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
